// File: rtl/rob.sv
// Reorder buffer: a circular FIFO of rob_packet_t entries (the ROB_PACKET type).
// Dispatch writes up to N entries per cycle in program order at the tail.
// Retire sees up to N oldest entries and frees as many as it reports.
// The tail can be restored to a checkpoint for branch mispredict recovery.
//
// Ports:
//   clock             in   system clock, all state updates on posedge
//   reset             in   synchronous active-low reset
//   rob_inputs        in   N dispatching packets, oldest in slot 0
//   rob_inputs_valid  in   number of valid rob_inputs slots, counted from slot 0
//   rob_spots         out  free entries, min(ROB_SZ - count, N)
//   rob_tail          out  current tail pointer (index plus wrap bit)
//   restore_valid     in   mispredict recovery this cycle
//   restore_tail      in   tail pointer to restore
//   rob_outputs       out  N oldest entries, slot i = entry (head + i) mod ROB_SZ
//   rob_outputs_valid out  min(count, N)
//   num_retiring      in   entries retired this cycle by the retire stage

package rob_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  t_new;
        logic [5:0]  t_old;
        logic [4:0]  arch_reg;
        logic        halt;
    } rob_packet_t;

endpackage

module rob
    import rob_pkg::*;
#(
    parameter int unsigned N      = 3,
    parameter int unsigned ROB_SZ = 8,
    parameter int unsigned PTR_W  = $clog2(ROB_SZ) + 1,
    parameter int unsigned CNT_W  = $clog2(N + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  rob_packet_t [N-1:0]      rob_inputs,
    input  logic        [CNT_W-1:0]  rob_inputs_valid,
    output logic        [CNT_W-1:0]  rob_spots,
    output logic        [PTR_W-1:0]  rob_tail,
    input  logic                     restore_valid,
    input  logic        [PTR_W-1:0]  restore_tail,
    output rob_packet_t [N-1:0]      rob_outputs,
    output logic        [CNT_W-1:0]  rob_outputs_valid,
    input  logic        [CNT_W-1:0]  num_retiring
);

    localparam int unsigned IDX_W = PTR_W - 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    rob_packet_t      entries_q [ROB_SZ];

    logic [PTR_W-1:0] count;
    logic [PTR_W-1:0] free_cnt;
    logic [CNT_W-1:0] disp_cnt;
    logic [CNT_W-1:0] ret_cnt;
    logic [IDX_W-1:0] wr_idx [N];
    logic [IDX_W-1:0] rd_idx [N];

    // Occupancy and its clamped views, all from registered state only so that
    // neither dispatch nor retire of this cycle is bypassed to the outputs.
    always_comb begin
        count    = tail_q - head_q;
        free_cnt = PTR_W'(ROB_SZ) - count;

        if (free_cnt > PTR_W'(N)) begin
            rob_spots = CNT_W'(N);
        end else begin
            rob_spots = CNT_W'(free_cnt);
        end

        if (count > PTR_W'(N)) begin
            rob_outputs_valid = CNT_W'(N);
        end else begin
            rob_outputs_valid = CNT_W'(count);
        end
    end

    assign rob_tail = tail_q;

    // Effective dispatch and retire counts; excess requests are dropped.
    // A restore suppresses dispatch entirely but retire still proceeds.
    always_comb begin
        disp_cnt = '0;
        if (!restore_valid) begin
            disp_cnt = (rob_inputs_valid > rob_spots) ? rob_spots : rob_inputs_valid;
        end
        ret_cnt = (num_retiring > rob_outputs_valid) ? rob_outputs_valid : num_retiring;
    end

    always_comb begin
        head_d = head_q + PTR_W'(ret_cnt);
        if (restore_valid) begin
            tail_d = restore_tail;
        end else begin
            tail_d = tail_q + PTR_W'(disp_cnt);
        end
    end

    // Index arithmetic wraps naturally in IDX_W bits since ROB_SZ is a power of two.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            wr_idx[i] = tail_q[IDX_W-1:0] + IDX_W'(i);
            rd_idx[i] = head_q[IDX_W-1:0] + IDX_W'(i);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Entry storage has no reset; contents are only observable through valid slots.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int j = 0; j < int'(N); j++) begin
                if (CNT_W'(j) < disp_cnt) begin
                    entries_q[wr_idx[j]] <= rob_inputs[j];
                end
            end
        end
    end

    // Slots beyond the valid count are forced to zero so retire never sees stale data.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            rob_outputs[i] = '0;
            if (CNT_W'(i) < rob_outputs_valid) begin
                rob_outputs[i] = entries_q[rd_idx[i]];
            end
        end
    end

endmodule

// File: tb/tb_rob.sv
module tb_rob;
    import rob_pkg::*;

    localparam int N      = 3;
    localparam int ROB_SZ = 8;
    localparam int PTR_W  = 4;
    localparam int CNT_W  = 2;
    localparam int PMOD   = 16;

    logic                    clock;
    logic                    reset;
    rob_packet_t [N-1:0]     rob_inputs;
    logic        [CNT_W-1:0] rob_inputs_valid;
    logic        [CNT_W-1:0] rob_spots;
    logic        [PTR_W-1:0] rob_tail;
    logic                    restore_valid;
    logic        [PTR_W-1:0] restore_tail;
    rob_packet_t [N-1:0]     rob_outputs;
    logic        [CNT_W-1:0] rob_outputs_valid;
    logic        [CNT_W-1:0] num_retiring;

    rob #(
        .N      (N),
        .ROB_SZ (ROB_SZ),
        .PTR_W  (PTR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .rob_inputs        (rob_inputs),
        .rob_inputs_valid  (rob_inputs_valid),
        .rob_spots         (rob_spots),
        .rob_tail          (rob_tail),
        .restore_valid     (restore_valid),
        .restore_tail      (restore_tail),
        .rob_outputs       (rob_outputs),
        .rob_outputs_valid (rob_outputs_valid),
        .num_retiring      (num_retiring)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          valid;
        int          spots;
        int          tail;
        rob_packet_t outs [N];
    } exp_t;

    exp_t        exp_q [$];
    rob_packet_t mq [$];   // in-flight entries, oldest first
    int          mhead;
    int          vectors;
    int          errors;

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Apply one cycle of stimulus and record what the ROB must show after the edge.
    task automatic step(input logic rst, input int nin, input int t0, input logic rv,
                        input int rt, input int nret);
        int   sz;
        int   vis;
        int   spots;
        int   r;
        int   d;
        int   new_sz;
        exp_t e;
        @(negedge clock);
        reset            = rst;
        rob_inputs_valid = CNT_W'(nin);
        restore_valid    = rv;
        restore_tail     = PTR_W'(rt);
        num_retiring     = CNT_W'(nret);
        for (int j = 0; j < N; j++) begin
            rob_inputs[j].pc       = $urandom;
            rob_inputs[j].t_new    = 6'(t0 + j);
            rob_inputs[j].t_old    = 6'($urandom);
            rob_inputs[j].arch_reg = 5'($urandom);
            rob_inputs[j].halt     = 1'($urandom);
        end

        sz    = mq.size();
        vis   = min2(sz, N);
        spots = min2(ROB_SZ - sz, N);
        if (!rst) begin
            mq.delete();
            mhead = 0;
        end else begin
            r = min2(nret, vis);
            repeat (r) void'(mq.pop_front());
            mhead = (mhead + r) % PMOD;
            if (rv) begin
                new_sz = ((rt % PMOD) - mhead + PMOD) % PMOD;
                assert (new_sz <= mq.size())
                else $error("restore_tail %0d outside [head+r, tail]", rt);
                while (mq.size() > new_sz) void'(mq.pop_back());
            end else begin
                d = min2(nin, spots);
                for (int j = 0; j < d; j++) mq.push_back(rob_inputs[j]);
            end
        end

        sz      = mq.size();
        e.valid = min2(sz, N);
        e.spots = min2(ROB_SZ - sz, N);
        e.tail  = (mhead + sz) % PMOD;
        for (int i = 0; i < N; i++) e.outs[i] = (i < e.valid) ? mq[i] : '0;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(1'b1, 0, 0, 1'b0, 0, 0);
    endtask

    // Monitor: one expected snapshot per posedge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("outputs_valid", 64'(rob_outputs_valid), 64'(e.valid));
                chk("spots", 64'(rob_spots), 64'(e.spots));
                chk("tail", 64'(rob_tail), 64'(e.tail));
                for (int i = 0; i < N; i++) begin
                    chk($sformatf("outputs[%0d]", i), 64'(rob_outputs[i]), 64'(e.outs[i]));
                end
            end
        end
    end

    initial begin
        int sz;
        int nret;
        int r;
        int rt;
        vectors          = 0;
        errors           = 0;
        mhead            = 0;
        reset            = 1'b0;
        rob_inputs       = '0;
        rob_inputs_valid = '0;
        restore_valid    = 1'b0;
        restore_tail     = '0;
        num_retiring     = '0;

        // Reset held two cycles, then idle.
        step(1'b0, 0, 0, 1'b0, 0, 0);
        step(1'b0, 0, 0, 1'b0, 0, 0);
        idle();

        // Basic dispatch, fill to full, dropped dispatch when full.
        step(1'b1, 3, 10, 1'b0, 0, 0);
        step(1'b1, 3, 13, 1'b0, 0, 0);
        step(1'b1, 2, 16, 1'b0, 0, 0);
        step(1'b1, 2, 30, 1'b0, 0, 0);
        idle();

        // Wrap: retire 3 then 3, dispatch two at indices 0 and 1, then drain three.
        step(1'b1, 0, 0, 1'b0, 0, 3);
        step(1'b1, 0, 0, 1'b0, 0, 3);
        step(1'b1, 2, 40, 1'b0, 0, 0);
        idle();
        step(1'b1, 0, 0, 1'b0, 0, 3);
        idle();

        // Restore with simultaneous retire and ignored dispatch.
        step(1'b0, 0, 0, 1'b0, 0, 0);
        step(1'b1, 3, 20, 1'b0, 0, 0);
        step(1'b1, 3, 23, 1'b0, 0, 0);
        step(1'b1, 2, 50, 1'b1, 3, 1);
        idle();

        // Over-retire empties the ROB; mid-operation reset.
        step(1'b0, 0, 0, 1'b0, 0, 0);
        step(1'b1, 2, 60, 1'b0, 0, 0);
        step(1'b1, 0, 0, 1'b0, 0, 3);
        idle();
        step(1'b1, 3, 70, 1'b0, 0, 0);
        step(1'b1, 2, 73, 1'b0, 0, 0);
        step(1'b0, 3, 80, 1'b0, 0, 2);
        idle();

        // Randomized traffic with occasional legal restores and rare resets.
        for (int k = 0; k < 400; k++) begin
            sz   = mq.size();
            nret = $urandom_range(0, N);
            r    = min2(nret, min2(sz, N));
            if ($urandom_range(0, 59) == 0) begin
                step(1'b0, $urandom_range(0, N), $urandom_range(0, 63), 1'b0, 0, nret);
            end else if ($urandom_range(0, 7) == 0) begin
                rt = (mhead + r + $urandom_range(0, sz - r)) % PMOD;
                step(1'b1, $urandom_range(0, N), $urandom_range(0, 63), 1'b1, rt, nret);
            end else begin
                step(1'b1, $urandom_range(0, N), $urandom_range(0, 63), 1'b0,
                     $urandom_range(0, PMOD - 1), nret);
            end
        end

        idle();
        @(posedge clock);
        #3;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
